// File: rtl/sr_flag_pkg.sv
// Shared types and constants for the SR flag arbiter and its helpers.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package sr_flag_pkg;

    // Sequencer states. One operation is IDLE -> DRIVE -> SETTLE.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DRIVE  = 2'd1,
        SETTLE = 2'd2
    } state_t;

    // Requester operation encoding on the op bus.
    localparam logic OP_SET = 1'b1;
    localparam logic OP_CLR = 1'b0;

endpackage

// File: rtl/sr_flag_arbiter_rr_pick.sv
// Combinational round-robin selector: the first asserted req at or after ptr, wrapping.
// Latency: zero cycles (pure combinational).
// Backpressure: none; vld simply reflects whether any req bit is high.
//
// Ports:
//   req  N-bit request vector
//   ptr  search start index (highest priority this round)
//   vld  any request present
//   idx  winning requester index (0 when vld is low)
module rr_pick #(
    parameter  int N  = 4,
    localparam int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic          vld,
    output logic [IW-1:0] idx
);

    // Walk offsets from the farthest to the nearest so the nearest hit
    // (smallest distance from ptr) is the final assignment and wins.
    always_comb begin
        vld = |req;
        idx = '0;
        for (int i = N - 1; i >= 0; i--) begin
            int c;
            c = int'(ptr) + i;
            if (c >= N) begin
                c = c - N;
            end
            if (req[c]) begin
                idx = IW'(c);
            end
        end
    end

endmodule

// File: rtl/sr_flag_arbiter.sv
// Round-robin arbiter/sequencer driving one-hot S/R pulses into a shared SR flag bank.
// Latency: req seen at arbitration edge -> gnt/s_out/r_out high next cycle; one op per 3 cycles.
// Backpressure: requesters hold req until their gnt pulse; requests during DRIVE/SETTLE wait for IDLE.
//
// Ports:
//   clk    rising-edge clock
//   rst    synchronous active-high reset
//   req    per-requester request (held until gnt)
//   op     per-requester operation, 1 = set, 0 = clear
//   addr   packed flag indices, requester i at [i*AW +: AW]
//   gnt    one-hot grant pulse during DRIVE
//   s_out  one-hot set pulse to the bank
//   r_out  one-hot reset pulse to the bank
//   flags  shadow copy of bank state
//   busy   high while an operation is in flight
//   err    pulse when the granted index is outside the bank
module sr_flag_arbiter
    import sr_flag_pkg::*;
#(
    parameter  int NREQ  = 4,
    parameter  int NFLAG = 8,
    localparam int AW    = $clog2(NFLAG)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      req,
    input  logic [NREQ-1:0]      op,
    input  logic [NREQ*AW-1:0]   addr,
    output logic [NREQ-1:0]      gnt,
    output logic [NFLAG-1:0]     s_out,
    output logic [NFLAG-1:0]     r_out,
    output logic [NFLAG-1:0]     flags,
    output logic                 busy,
    output logic                 err
);

    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

    // Bank size at index width + 1 so the bound compare is width-matched
    // and still correct when NFLAG is an exact power of two.
    localparam logic [AW:0] NFLAG_LIM = (AW + 1)'(NFLAG);

    localparam logic [NREQ-1:0]  ONE_REQ  = {{(NREQ - 1){1'b0}}, 1'b1};
    localparam logic [NFLAG-1:0] ONE_FLAG = {{(NFLAG - 1){1'b0}}, 1'b1};

    state_t            state_q, state_d;
    logic [IW-1:0]     ptr_q,   ptr_d;
    logic [IW-1:0]     win_q,   win_d;
    logic              op_q,    op_d;
    logic [AW-1:0]     addr_q,  addr_d;
    logic [NREQ-1:0]   gnt_q,   gnt_d;
    logic [NFLAG-1:0]  s_q,     s_d;
    logic [NFLAG-1:0]  r_q,     r_d;
    logic              err_q,   err_d;
    logic [NFLAG-1:0]  flags_q, flags_d;

    logic              pick_vld;
    logic [IW-1:0]     pick_idx;
    logic              sel_op;
    logic [AW-1:0]     sel_addr;
    logic              sel_in_range;
    logic              cap_in_range;
    logic [NFLAG-1:0]  sel_onehot;
    logic [NFLAG-1:0]  cap_onehot;

    rr_pick #(
        .N   (NREQ)
    ) u_rr_pick (
        .req (req),
        .ptr (ptr_q),
        .vld (pick_vld),
        .idx (pick_idx)
    );

    // Winner's operands, only meaningful when pick_vld is high.
    assign sel_op       = op[pick_idx];
    assign sel_addr     = addr[pick_idx*AW +: AW];
    assign sel_in_range = ({1'b0, sel_addr} < NFLAG_LIM);
    assign sel_onehot   = ONE_FLAG << sel_addr;

    // Captured operands used to update the shadow at the end of DRIVE.
    assign cap_in_range = ({1'b0, addr_q} < NFLAG_LIM);
    assign cap_onehot   = ONE_FLAG << addr_q;

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        win_d   = win_q;
        op_d    = op_q;
        addr_d  = addr_q;
        gnt_d   = '0;
        s_d     = '0;
        r_d     = '0;
        err_d   = 1'b0;
        flags_d = flags_q;

        case (state_q)
            IDLE: begin
                if (pick_vld) begin
                    win_d  = pick_idx;
                    op_d   = sel_op;
                    addr_d = sel_addr;
                    // Pulses are registered here so they are visible for
                    // exactly the DRIVE cycle.
                    gnt_d  = ONE_REQ << pick_idx;
                    if (!sel_in_range) begin
                        err_d = 1'b1;
                    end else if (sel_op == OP_SET) begin
                        s_d = sel_onehot;
                    end else begin
                        r_d = sel_onehot;
                    end
                    state_d = DRIVE;
                end
            end

            DRIVE: begin
                ptr_d = (win_q == IW'(NREQ - 1)) ? '0 : win_q + 1'b1;
                // Shadow tracks the bank as the pulse completes; an
                // out-of-range index touches nothing.
                if (cap_in_range) begin
                    if (op_q == OP_SET) begin
                        flags_d = flags_q | cap_onehot;
                    end else begin
                        flags_d = flags_q & ~cap_onehot;
                    end
                end
                state_d = SETTLE;
            end

            SETTLE: begin
                // Pulse outputs are already low: bank sees S=R=0 and holds.
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            win_q   <= '0;
            op_q    <= OP_CLR;
            addr_q  <= '0;
            gnt_q   <= '0;
            s_q     <= '0;
            r_q     <= '0;
            err_q   <= 1'b0;
            flags_q <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            win_q   <= win_d;
            op_q    <= op_d;
            addr_q  <= addr_d;
            gnt_q   <= gnt_d;
            s_q     <= s_d;
            r_q     <= r_d;
            err_q   <= err_d;
            flags_q <= flags_d;
        end
    end

    assign gnt   = gnt_q;
    assign s_out = s_q;
    assign r_out = r_q;
    assign err   = err_q;
    assign flags = flags_q;
    assign busy  = (state_q != IDLE);

endmodule

// File: tb/tb_sr_flag_arbiter.sv
// Scoreboard bench for sr_flag_arbiter (NREQ=4, NFLAG=6 so out-of-range indices exist).
// Expected grant/pulse tuples are queued when a request is driven and popped when gnt appears.
// Inputs change #1 after a clock edge; outputs are sampled on the falling edge.
module tb_sr_flag_arbiter;

    localparam int NREQ  = 4;
    localparam int NFLAG = 6;
    localparam int AW    = 3;

    typedef struct packed {
        logic [NREQ-1:0]  gnt;
        logic [NFLAG-1:0] s;
        logic [NFLAG-1:0] r;
        logic             err;
    } exp_t;

    logic                 clk = 1'b0;
    logic                 rst;
    logic [NREQ-1:0]      req;
    logic [NREQ-1:0]      op;
    logic [NREQ*AW-1:0]   addr;
    logic [NREQ-1:0]      gnt;
    logic [NFLAG-1:0]     s_out;
    logic [NFLAG-1:0]     r_out;
    logic [NFLAG-1:0]     flags;
    logic                 busy;
    logic                 err;

    int   n_tests = 0;
    int   n_fail  = 0;
    int   n_grants = 0;
    int   cyc = 0;
    int   gcyc [0:63];
    bit   prev_gnt = 1'b0;
    logic [NFLAG-1:0] exp_flags = '0;
    exp_t exp_q [$];

    sr_flag_arbiter #(
        .NREQ  (NREQ),
        .NFLAG (NFLAG)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .req   (req),
        .op    (op),
        .addr  (addr),
        .gnt   (gnt),
        .s_out (s_out),
        .r_out (r_out),
        .flags (flags),
        .busy  (busy),
        .err   (err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc = cyc + 1;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic expect_op(input logic [NREQ-1:0] g, input logic [NFLAG-1:0] s,
                             input logic [NFLAG-1:0] r, input logic e);
        exp_t x;
        x.gnt = g;
        x.s   = s;
        x.r   = r;
        x.err = e;
        exp_q.push_back(x);
    endtask

    // Returns #1 after the falling edge on which the n-th new grant appeared.
    task automatic wait_grants(input int n, input int budget);
        int target;
        int k;
        target = n_grants + n;
        k = 0;
        while (n_grants < target && k < budget) begin
            @(negedge clk);
            #1;
            k++;
        end
        if (n_grants < target) begin
            check_eq("grant_timeout", 32'(n_grants), 32'(target));
        end
    endtask

    task automatic wait_idle_check_flags(input string tag);
        int k;
        k = 0;
        while (busy && k < 20) begin
            @(negedge clk);
            #1;
            k++;
        end
        check_eq("idle_reached", 32'(busy), 32'(0));
        check_eq(tag, 32'(flags), 32'(exp_flags));
    endtask

    // Monitor: per-cycle invariants, scoreboard pops on grants, SETTLE quietness.
    always @(negedge clk) begin
        if (!rst) begin
            check_eq("invariant",
                     32'(((s_out & r_out) == '0) && ($countones(s_out | r_out) <= 1)
                         && ($countones(gnt) <= 1)),
                     32'(1));
            if (prev_gnt) begin
                check_eq("settle_quiet", 32'({gnt, s_out, r_out, err, busy}), 32'(1));
            end
            if (gnt != '0) begin
                if (exp_q.size() == 0) begin
                    check_eq("unexpected_gnt", 32'(gnt), 32'(0));
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check_eq("gnt",     32'(gnt),   32'(e.gnt));
                    check_eq("s_out",   32'(s_out), 32'(e.s));
                    check_eq("r_out",   32'(r_out), 32'(e.r));
                    check_eq("err",     32'(err),   32'(e.err));
                    check_eq("busy_dr", 32'(busy),  32'(1));
                    if (!e.err) begin
                        exp_flags = (exp_flags | e.s) & ~e.r;
                    end
                end
                n_grants++;
                if (n_grants < 64) gcyc[n_grants] = cyc;
            end else if (!prev_gnt) begin
                check_eq("idle_no_pulse", 32'({s_out, r_out, err}), 32'(0));
            end
        end
        prev_gnt = (gnt != '0);
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        // Reset held for two cycles with every requester asking.
        rst  = 1'b1;
        req  = 4'b1111;
        op   = 4'b0000;
        addr = {3'd3, 3'd2, 3'd1, 3'd0};
        repeat (2) begin
            @(negedge clk);
            #1;
            check_eq("rst_gnt",   32'(gnt),   32'(0));
            check_eq("rst_s",     32'(s_out), 32'(0));
            check_eq("rst_r",     32'(r_out), 32'(0));
            check_eq("rst_flags", 32'(flags), 32'(0));
            check_eq("rst_busy",  32'(busy),  32'(0));
            check_eq("rst_err",   32'(err),   32'(0));
        end
        // First grant after release goes to requester 0 (redundant clear of flag 0).
        expect_op(4'b0001, 6'h00, 6'h01, 1'b0);
        @(posedge clk);
        #1 rst = 1'b0;
        wait_grants(1, 20);
        req = '0;
        wait_idle_check_flags("flags_after_rst");

        // Single set: requester 1 sets flag 5.
        req  = 4'b0010;
        op   = 4'b0010;
        addr = 12'(5) << (1 * AW);
        expect_op(4'b0010, 6'h20, 6'h00, 1'b0);
        wait_grants(1, 20);
        req = '0;
        wait_idle_check_flags("flags_single_set");

        // Reset during DRIVE: requester 2 sets flag 4, but reset wins.
        req  = 4'b0100;
        op   = 4'b0100;
        addr = 12'(4) << (2 * AW);
        expect_op(4'b0100, 6'h10, 6'h00, 1'b0);
        wait_grants(1, 20);
        req = '0;
        rst = 1'b1;
        @(negedge clk);
        #1;
        check_eq("midrst_gnt",   32'(gnt),   32'(0));
        check_eq("midrst_s",     32'(s_out), 32'(0));
        check_eq("midrst_busy",  32'(busy),  32'(0));
        check_eq("midrst_flags", 32'(flags), 32'(0));
        exp_flags = '0;

        // Round-robin from ptr=0: all four held, ops set/clr alternating, addr i=i.
        @(posedge clk);
        #1;
        rst  = 1'b0;
        req  = 4'b1111;
        op   = 4'b0101;
        addr = {3'd3, 3'd2, 3'd1, 3'd0};
        expect_op(4'b0001, 6'h01, 6'h00, 1'b0);
        expect_op(4'b0010, 6'h00, 6'h02, 1'b0);
        expect_op(4'b0100, 6'h04, 6'h00, 1'b0);
        expect_op(4'b1000, 6'h00, 6'h08, 1'b0);
        expect_op(4'b0001, 6'h01, 6'h00, 1'b0);
        wait_grants(5, 60);
        req = '0;
        for (int i = n_grants - 3; i <= n_grants; i++) begin
            check_eq("rr_gap", 32'(gcyc[i] - gcyc[i-1]), 32'(3));
        end
        wait_idle_check_flags("flags_rr");

        // Set flag 3 via requester 2, then clear it via requester 0.
        req  = 4'b0100;
        op   = 4'b0100;
        addr = 12'(3) << (2 * AW);
        expect_op(4'b0100, 6'h08, 6'h00, 1'b0);
        wait_grants(1, 20);
        req = '0;
        wait_idle_check_flags("flags_set3");
        req  = 4'b0001;
        op   = 4'b0000;
        addr = 12'(3);
        expect_op(4'b0001, 6'h00, 6'h08, 1'b0);
        wait_grants(1, 20);
        req = '0;
        wait_idle_check_flags("flags_clr3");

        // Out of range: index 7 (set) and index 6 == NFLAG (clear).
        req  = 4'b0010;
        op   = 4'b0010;
        addr = 12'(7) << (1 * AW);
        expect_op(4'b0010, 6'h00, 6'h00, 1'b1);
        wait_grants(1, 20);
        req = '0;
        wait_idle_check_flags("flags_oor7");
        req  = 4'b1000;
        op   = 4'b0000;
        addr = 12'(6) << (3 * AW);
        expect_op(4'b1000, 6'h00, 6'h00, 1'b1);
        wait_grants(1, 20);
        req = '0;
        wait_idle_check_flags("flags_oor6");

        // Nothing further may be granted once all requests are gone.
        repeat (6) @(negedge clk);
        #1;
        check_eq("sb_empty", 32'(exp_q.size()), 32'(0));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
